// File: rtl/instr_encoder.sv
// instr_encoder: two-stage valid/ready RV32I encoder that packs decoded fields and a 32-bit immediate into an instruction word
//   clk, rst_n                  : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready           : request handshake
//   in_fmt                      : 0=R 1=I 2=S 3=B 4=U 5=J, 6-7 illegal
//   in_opcode..in_imm           : decoded fields and full immediate
//   out_valid/out_ready         : result handshake
//   out_instr/out_err/out_err_code : packed word (0 on error), error flag, 0/1 range/2 misaligned/3 bad format
//   cnt_ok/cnt_err              : saturating counts of delivered good and rejected words
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [1:0]       out_err_code,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);
    logic        s1_valid;
    logic [31:0] s1_instr;
    logic [1:0]  s1_code;
    logic        s2_load;
    logic [31:0] word;
    logic [1:0]  code;
    logic        rng_is;
    logic        rng_b;
    logic        rng_j;
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    // an immediate fits when every bit above the field's sign bit copies it
    assign rng_is = !((&in_imm[31:11]) || !(|in_imm[31:11]));
    assign rng_b  = !((&in_imm[31:12]) || !(|in_imm[31:12]));
    assign rng_j  = !((&in_imm[31:20]) || !(|in_imm[31:20]));
    always_comb begin
        word = '0;
        case (in_fmt)
            3'd0: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
            3'd4: word = {in_imm[31:12], in_rd, in_opcode};
            3'd5: word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default: word = '0;
        endcase
    end
    always_comb begin
        code = (in_fmt[2:1] == 2'b11)                              ? 2'd3 :
               ((in_fmt == 3'd3 || in_fmt == 3'd5) && in_imm[0])   ? 2'd2 :
               (in_fmt == 3'd4 && |in_imm[11:0])                   ? 2'd2 :
               ((in_fmt == 3'd1 || in_fmt == 3'd2) && rng_is)      ? 2'd1 :
               (in_fmt == 3'd3 && rng_b)                           ? 2'd1 :
               (in_fmt == 3'd5 && rng_j)                           ? 2'd1 : 2'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_code  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_instr <= (code != 2'd0) ? 32'd0 : word;
                s1_code  <= code;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_err      <= 1'b0;
            out_err_code <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr    <= s1_instr;
                out_err      <= (s1_code != 2'd0);
                out_err_code <= s1_code;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ok  <= '0;
            cnt_err <= '0;
        end else if (out_valid && out_ready) begin
            if (out_err && !(&cnt_err))
                cnt_err <= cnt_err + CNT_W'(1);
            if (!out_err && !(&cnt_ok))
                cnt_ok <= cnt_ok + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder with a small-counter instance for saturation
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [1:0]  out_err_code;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_instr;
    logic        s_out_err;
    logic [1:0]  s_out_err_code;
    logic [3:0]  s_cnt_ok;
    logic [3:0]  s_cnt_err;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  code;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } exp_t;
    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  code;
        int          cyc;
    } got_t;

    exp_t exp_q[$];
    got_t got_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   mod_ok = 0;
    int   mod_err = 0;
    logic in_fire;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .out_err_code(out_err_code), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    instr_encoder #(.CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
        .out_err(s_out_err), .out_err_code(s_out_err_code), .cnt_ok(s_cnt_ok), .cnt_err(s_cnt_err)
    );

    // Reference encoder written field by field from the instruction formats
    function automatic exp_t model(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm);
        exp_t e;
        int   s;
        s = $signed(imm);
        e.fmt = f;
        e.imm = imm;
        e.instr = '0;
        e.code = 2'd0;
        if (f > 3'd5) e.code = 2'd3;
        else if ((f == 3'd3 || f == 3'd5) && imm[0]) e.code = 2'd2;
        else if (f == 3'd4 && imm[11:0] != 12'd0) e.code = 2'd2;
        else if ((f == 3'd1 || f == 3'd2) && (s < -2048 || s > 2047)) e.code = 2'd1;
        else if (f == 3'd3 && (s < -4096 || s > 4095)) e.code = 2'd1;
        else if (f == 3'd5 && (s < -1048576 || s > 1048575)) e.code = 2'd1;
        e.err = (e.code != 2'd0);
        if (!e.err) begin
            e.instr[6:0] = op;
            if (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5) e.instr[11:7] = rd;
            if (f <= 3'd3) begin
                e.instr[14:12] = f3;
                e.instr[19:15] = rs1;
            end
            if (f == 3'd0 || f == 3'd2 || f == 3'd3) e.instr[24:20] = rs2;
            case (f)
                3'd0: e.instr[31:25] = f7;
                3'd1: e.instr[31:20] = imm[11:0];
                3'd2: begin
                    e.instr[31:25] = imm[11:5];
                    e.instr[11:7]  = imm[4:0];
                end
                3'd3: begin
                    e.instr[31]    = imm[12];
                    e.instr[30:25] = imm[10:5];
                    e.instr[11:8]  = imm[4:1];
                    e.instr[7]     = imm[11];
                end
                3'd4: e.instr[31:12] = imm[31:12];
                3'd5: begin
                    e.instr[31]    = imm[20];
                    e.instr[30:21] = imm[10:1];
                    e.instr[20]    = imm[11];
                    e.instr[19:12] = imm[19:12];
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    // Decoder-side immediate extraction
    function automatic logic [31:0] dec_imm(input logic [2:0] f, input logic [31:0] i);
        case (f)
            3'd1: return {{20{i[31]}}, i[31:20]};
            3'd2: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4: return {i[31:12], 12'd0};
            3'd5: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [31:0] imm);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = 7'h20; in_imm = imm; in_valid = 1'b1;
    endtask

    // Advance one clock: record handshakes seen just before the rising edge
    task automatic tick();
        got_t g;
        @(negedge clk);
        in_fire = in_valid && in_ready;
        if (in_fire)
            exp_q.push_back(model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
        if (out_valid && out_ready) begin
            g.instr = out_instr; g.err = out_err; g.code = out_err_code; g.cyc = cyc;
            got_q.push_back(g);
            if (out_err) mod_err++;
            else mod_ok++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        vectors += 7;
        if (out_valid !== 1'b0)     begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_instr !== 32'd0)    begin miscompares++; $display("FAIL reset_instr got %h want 0", out_instr); end
        if (out_err !== 1'b0)       begin miscompares++; $display("FAIL reset_err got %b want 0", out_err); end
        if (out_err_code !== 2'd0)  begin miscompares++; $display("FAIL reset_code got %0d want 0", out_err_code); end
        if (cnt_ok !== 16'd0)       begin miscompares++; $display("FAIL reset_cnt_ok got %0d want 0", cnt_ok); end
        if (cnt_err !== 16'd0)      begin miscompares++; $display("FAIL reset_cnt_err got %0d want 0", cnt_err); end
        if (in_ready !== 1'b1)      begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        got_t g;
        exp_q.delete(); got_q.delete();
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_lat1 out_valid got %b want 0", out_valid); end
        tick();
        vectors += 2;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_lat2 out_valid got %b want 1", out_valid); end
        if (out_instr !== 32'hFFF0_0093) begin miscompares++; $display("FAIL addi_word got %h want fff00093", out_instr); end
        repeat (2) tick();
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++; $display("FAIL addi_count got %0d want 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            vectors++;
            if (g.err !== 1'b0) begin miscompares++; $display("FAIL addi_err got %b want 0", g.err); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [4] = '{32'h0020_A423, 32'hFE00_0EE3, 32'h1234_52B7, 32'h0000_006F};
        got_t g;
        int   c0;
        int   ok0;
        exp_q.delete(); got_q.delete();
        ok0 = int'(cnt_ok);
        set_req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);         tick();
        set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC); tick();
        set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000); tick();
        set_req(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);         tick();
        in_valid = 1'b0;
        repeat (4) tick();
        vectors++;
        if (got_q.size() != 4) begin
            miscompares++; $display("FAIL b2b_count got %0d want 4", got_q.size());
        end else begin
            c0 = got_q[0].cyc;
            for (int i = 0; i < 4; i++) begin
                g = got_q.pop_front();
                vectors += 3;
                if (g.instr !== want[i]) begin miscompares++; $display("FAIL b2b_word%0d got %h want %h", i, g.instr, want[i]); end
                if (g.err !== 1'b0)      begin miscompares++; $display("FAIL b2b_err%0d got %b want 0", i, g.err); end
                if (g.cyc != c0 + i)     begin miscompares++; $display("FAIL b2b_cycle%0d got %0d want %0d", i, g.cyc, c0 + i); end
            end
        end
        vectors++;
        if (int'(cnt_ok) != ok0 + 4) begin miscompares++; $display("FAIL b2b_cnt_ok got %0d want %0d", cnt_ok, ok0 + 4); end
    endtask

    task automatic test_errors();
        logic [1:0] want [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
        got_t g;
        exp_q.delete(); got_q.delete();
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);      tick();
        set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);         tick();
        set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_1001); tick();
        set_req(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);         tick();
        in_valid = 1'b0;
        repeat (4) tick();
        vectors++;
        if (got_q.size() != 4) begin
            miscompares++; $display("FAIL err_count got %0d want 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                g = got_q.pop_front();
                vectors += 3;
                if (g.instr !== 32'd0)  begin miscompares++; $display("FAIL err_word%0d got %h want 0", i, g.instr); end
                if (g.err !== 1'b1)     begin miscompares++; $display("FAIL err_flag%0d got %b want 1", i, g.err); end
                if (g.code !== want[i]) begin miscompares++; $display("FAIL err_code%0d got %0d want %0d", i, g.code, want[i]); end
            end
        end
        vectors++;
        if (cnt_err !== 16'd4) begin miscompares++; $display("FAIL err_cnt got %0d want 4", cnt_err); end
    endtask

    task automatic test_backpressure();
        logic [31:0] want [3] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
        logic [31:0] snap;
        got_t g;
        exp_t e;
        int   acc = 0;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1); tick(); if (in_fire) acc++;
        set_req(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2); tick(); if (in_fire) acc++;
        set_req(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3);
        vectors += 3;
        if (acc != 2)           begin miscompares++; $display("FAIL bp_accepted got %0d want 2", acc); end
        if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid got %b want 1", out_valid); end
        snap = out_instr;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (in_fire) acc++;
            vectors += 3;
            if (out_valid !== 1'b1)   begin miscompares++; $display("FAIL bp_hold_valid t%0d got %b want 1", t, out_valid); end
            if (out_instr !== snap)   begin miscompares++; $display("FAIL bp_hold_instr t%0d got %h want %h", t, out_instr, snap); end
            if (out_instr !== want[0]) begin miscompares++; $display("FAIL bp_hold_word t%0d got %h want %h", t, out_instr, want[0]); end
        end
        out_ready = 1'b1;
        for (int t = 0; t < 10 && acc < 3; t++) begin
            tick();
            if (in_fire) acc++;
        end
        in_valid = 1'b0;
        repeat (4) tick();
        vectors++;
        if (got_q.size() != 3 || exp_q.size() != 3) begin
            miscompares++; $display("FAIL bp_count got %0d want 3 (pushed %0d)", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                vectors += 2;
                if (g.instr !== want[i]) begin miscompares++; $display("FAIL bp_order%0d got %h want %h", i, g.instr, want[i]); end
                if (g.instr !== e.instr) begin miscompares++; $display("FAIL bp_model%0d got %h want %h", i, g.instr, e.instr); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        got_t g;
        out_ready = 1'b0;
        set_req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0); tick();
        set_req(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd9); tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_full got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors += 6;
        if (out_valid !== 1'b0)    begin miscompares++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
        if (out_instr !== 32'd0)   begin miscompares++; $display("FAIL rst_async_instr got %h want 0", out_instr); end
        if (out_err_code !== 2'd0) begin miscompares++; $display("FAIL rst_async_code got %0d want 0", out_err_code); end
        if (cnt_ok !== 16'd0)      begin miscompares++; $display("FAIL rst_async_cnt_ok got %0d want 0", cnt_ok); end
        if (cnt_err !== 16'd0)     begin miscompares++; $display("FAIL rst_async_cnt_err got %0d want 0", cnt_err); end
        if (s_cnt_err !== 4'd0)    begin miscompares++; $display("FAIL rst_async_small got %0d want 0", s_cnt_err); end
        exp_q.delete(); got_q.delete();
        mod_ok = 0; mod_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        set_req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_post_lat1 got %b want 0", out_valid); end
        tick();
        vectors += 2;
        if (out_valid !== 1'b1)         begin miscompares++; $display("FAIL rst_post_lat2 got %b want 1", out_valid); end
        if (out_instr !== 32'h0020_A423) begin miscompares++; $display("FAIL rst_post_word got %h want 0020a423", out_instr); end
        repeat (2) tick();
        vectors++;
        if (got_q.size() != 1) begin miscompares++; $display("FAIL rst_post_count got %0d want 1", got_q.size()); end
        else g = got_q.pop_front();
        exp_q.delete();
    endtask

    task automatic test_roundtrip();
        got_t        g;
        exp_t        e;
        logic [31:0] r;
        logic [31:0] imm;
        logic [2:0]  f;
        int          sent = 0;
        int          t = 0;
        exp_q.delete(); got_q.delete();
        while (sent < 40 && t < 600) begin
            if (!in_valid) begin
                f = 3'($urandom_range(1, 5));
                r = $urandom;
                case (f)
                    3'd1, 3'd2: imm = {{20{r[11]}}, r[11:0]};
                    3'd3:       imm = {{19{r[12]}}, r[12:1], 1'b0};
                    3'd4:       imm = {r[31:12], 12'd0};
                    default:    imm = {{11{r[20]}}, r[20:1], 1'b0};
                endcase
                set_req(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            t++;
            if (in_fire) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        vectors++;
        if (sent != 40 || got_q.size() != 40 || exp_q.size() != 40) begin
            miscompares++; $display("FAIL rt_count sent %0d got %0d want 40", sent, got_q.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                vectors += 3;
                if (g.err !== 1'b0) begin miscompares++; $display("FAIL rt_err%0d got %b want 0", i, g.err); end
                if (g.instr !== e.instr) begin miscompares++; $display("FAIL rt_word%0d got %h want %h", i, g.instr, e.instr); end
                if (dec_imm(e.fmt, g.instr) !== e.imm) begin
                    miscompares++; $display("FAIL rt_imm%0d fmt %0d got %h want %h", i, e.fmt, dec_imm(e.fmt, g.instr), e.imm);
                end
            end
        end
    endtask

    task automatic test_saturation();
        exp_q.delete(); got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_req(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        vectors += 5;
        if (s_cnt_err !== 4'hF)  begin miscompares++; $display("FAIL sat_small_err got %0d want 15", s_cnt_err); end
        if (s_cnt_ok !== 4'hF)   begin miscompares++; $display("FAIL sat_small_ok got %0d want 15", s_cnt_ok); end
        if (mod_err != 17)       begin miscompares++; $display("FAIL sat_delivered got %0d want 17", mod_err); end
        if (int'(cnt_err) != mod_err) begin miscompares++; $display("FAIL sat_cnt_err got %0d want %0d", cnt_err, mod_err); end
        if (int'(cnt_ok) != mod_ok)   begin miscompares++; $display("FAIL sat_cnt_ok got %0d want %0d", cnt_ok, mod_ok); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0;
        in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        out_ready = 1'b1;
        in_fire = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_reset_midflight();
        test_roundtrip();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
